// File: rtl/hist_frame_seq_if.sv
// Signal bundle between the histogram-equalization frame sequencer and its
// video, CDF-engine and LUT-bank neighbours.
interface hist_frame_seq_if #(
  parameter int SKIP_W = 8
);
  logic              enable_i;
  logic              video_sop_i;
  logic              video_eop_i;
  logic              cdf_clean_i;
  logic              cdf_update_i;
  logic [7:0]        cdf_update_addr_i;
  logic              err_clr_i;
  logic              hist_en_o;
  logic              cdf_start_o;
  logic              lut_wr_en_o;
  logic              lut_wr_bank_o;
  logic              lut_rd_bank_o;
  logic              lut_ready_o;
  logic [SKIP_W-1:0] skip_cnt_o;
  logic              err_seq_o;
  logic              err_addr_o;
  logic              err_timeout_o;

  // Environment side: drives video/CDF events, observes sequencer outputs.
  modport master (
    output enable_i, video_sop_i, video_eop_i, cdf_clean_i, cdf_update_i,
           cdf_update_addr_i, err_clr_i,
    input  hist_en_o, cdf_start_o, lut_wr_en_o, lut_wr_bank_o, lut_rd_bank_o,
           lut_ready_o, skip_cnt_o, err_seq_o, err_addr_o, err_timeout_o
  );

  modport slave (
    input  enable_i, video_sop_i, video_eop_i, cdf_clean_i, cdf_update_i,
           cdf_update_addr_i, err_clr_i,
    output hist_en_o, cdf_start_o, lut_wr_en_o, lut_wr_bank_o, lut_rd_bank_o,
           lut_ready_o, skip_cnt_o, err_seq_o, err_addr_o, err_timeout_o
  );
endinterface

// File: rtl/hist_frame_seq.sv
// Frame-level sequencer for histogram equalization: gates accumulation, kicks the
// CDF/LUT engine, checks its LUT writes and ping-pongs two LUT banks at start-of-frame.
module hist_frame_seq #(
  parameter int LUT_ENTRIES = 256,
  parameter int TIMEOUT     = 4096,
  parameter int SKIP_W      = 8
) (
  input logic           clk,
  input logic           rst,
  hist_frame_seq_if.slave bus
);
  localparam int CNT_W = 9;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_SOP, ACCUM, LOAD, CALC, SWAP_PEND
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  upd_cnt_q, upd_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              hist_en_q, hist_en_d;
  logic              cdf_start_q, cdf_start_d;
  logic              lut_wr_en_q, lut_wr_en_d;
  logic              rd_bank_q, rd_bank_d;
  logic              wr_bank_q, wr_bank_d;
  logic              ready_q, ready_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic              err_seq_q, err_seq_d;
  logic              err_addr_q, err_addr_d;
  logic              err_tmo_q, err_tmo_d;
  logic              tmo_hit;
  logic              busy;

  assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
  assign busy    = (state_q == LOAD) || (state_q == CALC);

  always_comb begin
    state_d     = state_q;
    upd_cnt_d   = upd_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    hist_en_d   = hist_en_q;
    cdf_start_d = 1'b0;
    lut_wr_en_d = 1'b0;
    rd_bank_d   = rd_bank_q;
    ready_d     = ready_q;
    // Clear is applied first so that an error raised this cycle still sticks.
    skip_d      = bus.err_clr_i ? '0   : skip_q;
    err_seq_d   = bus.err_clr_i ? 1'b0 : err_seq_q;
    err_addr_d  = bus.err_clr_i ? 1'b0 : err_addr_q;
    err_tmo_d   = bus.err_clr_i ? 1'b0 : err_tmo_q;

    if (!bus.enable_i) begin
      state_d   = IDLE;
      hist_en_d = 1'b0;
    end else begin
      if (bus.cdf_update_i && (state_q != CALC)) err_addr_d = 1'b1;
      if (bus.video_sop_i && busy && (skip_d != '1)) skip_d = skip_d + SKIP_W'(1);

      case (state_q)
        IDLE: state_d = WAIT_SOP;
        WAIT_SOP: begin
          if (bus.video_sop_i) begin
            state_d   = ACCUM;
            hist_en_d = 1'b1;
          end
        end
        ACCUM: begin
          if (bus.video_eop_i) begin
            state_d     = LOAD;
            hist_en_d   = 1'b0;
            cdf_start_d = 1'b1;
            upd_cnt_d   = '0;
            tmo_cnt_d   = '0;
          end else if (bus.video_sop_i) begin
            err_seq_d = 1'b1;
          end
        end
        LOAD: begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          if (tmo_hit) begin
            state_d   = WAIT_SOP;
            err_tmo_d = 1'b1;
          end else if (bus.cdf_clean_i) begin
            state_d = CALC;
          end
        end
        CALC: begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          if (bus.cdf_update_i) begin
            lut_wr_en_d = 1'b1;
            upd_cnt_d   = upd_cnt_q + CNT_W'(1);
            if (bus.cdf_update_addr_i != upd_cnt_q[7:0]) err_addr_d = 1'b1;
          end
          // A pass completing on the very last allowed cycle is kept.
          if (upd_cnt_d == CNT_W'(LUT_ENTRIES)) begin
            state_d = SWAP_PEND;
          end else if (tmo_hit) begin
            state_d   = WAIT_SOP;
            err_tmo_d = 1'b1;
          end
        end
        SWAP_PEND: begin
          if (bus.video_sop_i) begin
            state_d   = ACCUM;
            hist_en_d = 1'b1;
            rd_bank_d = ~rd_bank_q;
            ready_d   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    wr_bank_d = ~rd_bank_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      upd_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      hist_en_q   <= 1'b0;
      cdf_start_q <= 1'b0;
      lut_wr_en_q <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_bank_q   <= 1'b1;
      ready_q     <= 1'b0;
      skip_q      <= '0;
      err_seq_q   <= 1'b0;
      err_addr_q  <= 1'b0;
      err_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      upd_cnt_q   <= upd_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      hist_en_q   <= hist_en_d;
      cdf_start_q <= cdf_start_d;
      lut_wr_en_q <= lut_wr_en_d;
      rd_bank_q   <= rd_bank_d;
      wr_bank_q   <= wr_bank_d;
      ready_q     <= ready_d;
      skip_q      <= skip_d;
      err_seq_q   <= err_seq_d;
      err_addr_q  <= err_addr_d;
      err_tmo_q   <= err_tmo_d;
    end
  end

  assign bus.hist_en_o     = hist_en_q;
  assign bus.cdf_start_o   = cdf_start_q;
  assign bus.lut_wr_en_o   = lut_wr_en_q;
  assign bus.lut_wr_bank_o = wr_bank_q;
  assign bus.lut_rd_bank_o = rd_bank_q;
  assign bus.lut_ready_o   = ready_q;
  assign bus.skip_cnt_o    = skip_q;
  assign bus.err_seq_o     = err_seq_q;
  assign bus.err_addr_o    = err_addr_q;
  assign bus.err_timeout_o = err_tmo_q;
endmodule

// File: tb/tb_hist_frame_seq.sv
// Directed bench for hist_frame_seq: full passes, bank ping-pong, skip counting,
// error flags, timeout, enable drop and asynchronous reset.
module tb_hist_frame_seq;
  logic clk;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   wrCount = 0;
  int   startCount = 0;
  int   bankErr = 0;
  int   wrBase;
  int   startBase;

  hist_frame_seq_if #(.SKIP_W(8)) bus ();

  hist_frame_seq #(.LUT_ENTRIES(256), .TIMEOUT(4096), .SKIP_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse counters and the bank-inverse invariant, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.lut_wr_en_o === 1'b1) wrCount++;
    if (bus.cdf_start_o === 1'b1) startCount++;
    if (bus.lut_wr_bank_o !== ~bus.lut_rd_bank_o) bankErr++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic sop, input logic eop, input logic clean,
                               input logic upd, input logic [7:0] addr, input int cycles);
    bus.video_sop_i       = sop;
    bus.video_eop_i       = eop;
    bus.cdf_clean_i       = clean;
    bus.cdf_update_i      = upd;
    bus.cdf_update_addr_i = addr;
    tick(cycles);
    bus.video_sop_i  = 1'b0;
    bus.video_eop_i  = 1'b0;
    bus.cdf_clean_i  = 1'b0;
    bus.cdf_update_i = 1'b0;
  endtask

  task automatic pulseErrClr();
    bus.err_clr_i = 1'b1;
    tick(1);
    bus.err_clr_i = 1'b0;
  endtask

  // Remaining accumulation cycles of a frame, ending with the eop edge.
  task automatic accumToEop();
    applyStimulus(0, 0, 0, 0, 8'h00, 98);
    applyStimulus(0, 1, 0, 0, 8'h00, 1);
  endtask

  task automatic runUpdates(input int count, input int badIdx);
    logic [7:0] a;
    for (int i = 0; i < count; i++) begin
      a = (i == badIdx) ? 8'd5 : 8'(i);
      applyStimulus(0, 0, 0, 1, a, 1);
    end
  endtask

  task automatic loadCalc(input int badIdx);
    applyStimulus(0, 0, 0, 0, 8'h00, 259);
    applyStimulus(0, 0, 1, 0, 8'h00, 1);
    runUpdates(256, badIdx);
    applyStimulus(0, 0, 0, 0, 8'h00, 2);
  endtask

  initial begin
    rst = 1'b1;
    bus.enable_i = 1'b0;
    bus.err_clr_i = 1'b0;
    bus.video_sop_i = 1'b0;
    bus.video_eop_i = 1'b0;
    bus.cdf_clean_i = 1'b0;
    bus.cdf_update_i = 1'b0;
    bus.cdf_update_addr_i = 8'h00;
    tick(2);
    checkOutput("rst_hist_en", bus.hist_en_o, 0);
    checkOutput("rst_cdf_start", bus.cdf_start_o, 0);
    checkOutput("rst_rd_bank", bus.lut_rd_bank_o, 0);
    checkOutput("rst_wr_bank", bus.lut_wr_bank_o, 1);
    checkOutput("rst_ready", bus.lut_ready_o, 0);
    checkOutput("rst_skip", bus.skip_cnt_o, 0);
    rst = 1'b0;

    // Test 1: first full pass and first swap
    bus.enable_i = 1'b1;
    tick(1);
    checkOutput("t1_wait_hist_en", bus.hist_en_o, 0);
    applyStimulus(1, 0, 0, 0, 8'h00, 1);
    checkOutput("t1_accum_hist_en", bus.hist_en_o, 1);
    startBase = startCount;
    accumToEop();
    checkOutput("t1_cdf_start", bus.cdf_start_o, 1);
    checkOutput("t1_hist_en_off", bus.hist_en_o, 0);
    tick(1);
    checkOutput("t1_cdf_start_end", bus.cdf_start_o, 0);
    wrBase = wrCount;
    loadCalc(-1);
    checkOutput("t1_start_pulses", startCount - startBase, 1);
    checkOutput("t1_wr_pulses", wrCount - wrBase, 256);
    checkOutput("t1_ready_before_sop", bus.lut_ready_o, 0);
    applyStimulus(1, 0, 0, 0, 8'h00, 1);
    checkOutput("t1_rd_bank", bus.lut_rd_bank_o, 1);
    checkOutput("t1_wr_bank", bus.lut_wr_bank_o, 0);
    checkOutput("t1_ready", bus.lut_ready_o, 1);
    checkOutput("t1_hist_en", bus.hist_en_o, 1);
    checkOutput("t1_errors", {bus.err_seq_o, bus.err_addr_o, bus.err_timeout_o}, 0);

    // Test 2: two more frames toggle the read bank 1->0->1
    accumToEop();
    loadCalc(-1);
    applyStimulus(1, 0, 0, 0, 8'h00, 1);
    checkOutput("t2_rd_bank_a", bus.lut_rd_bank_o, 0);
    accumToEop();
    loadCalc(-1);
    applyStimulus(1, 0, 0, 0, 8'h00, 1);
    checkOutput("t2_rd_bank_b", bus.lut_rd_bank_o, 1);

    // Test 3: sop twice during CALC counts skipped frames
    accumToEop();
    applyStimulus(0, 0, 0, 0, 8'h00, 259);
    applyStimulus(0, 0, 1, 0, 8'h00, 1);
    applyStimulus(1, 0, 0, 0, 8'h00, 1);
    applyStimulus(0, 0, 0, 0, 8'h00, 1);
    applyStimulus(1, 0, 0, 0, 8'h00, 1);
    checkOutput("t3_skip", bus.skip_cnt_o, 2);
    wrBase = wrCount;
    runUpdates(256, -1);
    applyStimulus(0, 0, 0, 0, 8'h00, 2);
    checkOutput("t3_wr_pulses", wrCount - wrBase, 256);
    applyStimulus(1, 0, 0, 0, 8'h00, 1);
    checkOutput("t3_rd_bank", bus.lut_rd_bank_o, 0);
    pulseErrClr();
    checkOutput("t3_skip_clr", bus.skip_cnt_o, 0);

    // Test 4: address and sequence errors
    applyStimulus(0, 0, 0, 1, 8'h10, 1);
    checkOutput("t4_accum_wr_en", bus.lut_wr_en_o, 0);
    checkOutput("t4_accum_err_addr", bus.err_addr_o, 1);
    pulseErrClr();
    checkOutput("t4_err_addr_clr", bus.err_addr_o, 0);
    applyStimulus(1, 0, 0, 0, 8'h00, 1);
    checkOutput("t4_err_seq", bus.err_seq_o, 1);
    checkOutput("t4_seq_hist_en", bus.hist_en_o, 1);
    pulseErrClr();
    checkOutput("t4_err_seq_clr", bus.err_seq_o, 0);
    applyStimulus(0, 0, 0, 0, 8'h00, 50);
    applyStimulus(1, 1, 0, 0, 8'h00, 1);
    checkOutput("t4_sop_eop_start", bus.cdf_start_o, 1);
    checkOutput("t4_sop_eop_no_err", bus.err_seq_o, 0);
    wrBase = wrCount;
    loadCalc(6);
    checkOutput("t4_err_addr_order", bus.err_addr_o, 1);
    checkOutput("t4_wr_pulses", wrCount - wrBase, 256);
    applyStimulus(1, 0, 0, 0, 8'h00, 1);
    checkOutput("t4_rd_bank", bus.lut_rd_bank_o, 1);

    // Test 5: no cdf_clean -> timeout after 4096 cycles in LOAD
    pulseErrClr();
    accumToEop();
    tick(4095);
    checkOutput("t5_no_timeout_yet", bus.err_timeout_o, 0);
    tick(1);
    checkOutput("t5_timeout", bus.err_timeout_o, 1);
    checkOutput("t5_hist_en", bus.hist_en_o, 0);
    checkOutput("t5_rd_bank", bus.lut_rd_bank_o, 1);
    applyStimulus(1, 0, 0, 0, 8'h00, 1);
    checkOutput("t5_wait_sop_accum", bus.hist_en_o, 1);
    checkOutput("t5_rd_bank_after_sop", bus.lut_rd_bank_o, 1);

    // Test 6: enable drop mid-CALC abandons the pass
    pulseErrClr();
    accumToEop();
    applyStimulus(0, 0, 0, 0, 8'h00, 259);
    applyStimulus(0, 0, 1, 0, 8'h00, 1);
    runUpdates(100, -1);
    bus.enable_i = 1'b0;
    applyStimulus(0, 0, 0, 1, 8'd100, 1);
    checkOutput("t6_disable_wr_en", bus.lut_wr_en_o, 0);
    checkOutput("t6_disable_hist_en", bus.hist_en_o, 0);
    bus.enable_i = 1'b1;
    tick(1);
    checkOutput("t6_rd_bank_held", bus.lut_rd_bank_o, 1);
    checkOutput("t6_ready_held", bus.lut_ready_o, 1);
    applyStimulus(1, 0, 0, 0, 8'h00, 1);
    checkOutput("t6_restart_hist_en", bus.hist_en_o, 1);
    checkOutput("t6_no_swap", bus.lut_rd_bank_o, 1);
    accumToEop();
    loadCalc(-1);
    applyStimulus(1, 0, 0, 0, 8'h00, 1);
    checkOutput("t6_swap_after", bus.lut_rd_bank_o, 0);

    // Asynchronous reset in the middle of CALC
    accumToEop();
    applyStimulus(0, 0, 0, 0, 8'h00, 259);
    applyStimulus(0, 0, 1, 0, 8'h00, 1);
    applyStimulus(0, 0, 0, 1, 8'h00, 50);
    checkOutput("t6_pre_rst_wr_en", bus.lut_wr_en_o, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_arst_wr_en", bus.lut_wr_en_o, 0);
    checkOutput("t6_arst_hist_en", bus.hist_en_o, 0);
    checkOutput("t6_arst_rd_bank", bus.lut_rd_bank_o, 0);
    checkOutput("t6_arst_wr_bank", bus.lut_wr_bank_o, 1);
    checkOutput("t6_arst_ready", bus.lut_ready_o, 0);
    checkOutput("t6_arst_errors", {bus.err_seq_o, bus.err_addr_o, bus.err_timeout_o}, 0);
    tick(2);
    rst = 1'b0;
    tick(2);
    checkOutput("bank_inverse_violations", bankErr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
